dac_serial_rx: RTL and testbench
================================

Name: dac_serial_rx

Overview:
- Receiver for the 3-wire DAC programming interface (serial clock, active-low sync, data), i.e. the listening end of the stream the NIM+ logic drives on DAC_SER_CLK/DAC_NSYNC/DAC_DIN.
- Oversamples the three lines in the fabric clock domain, deserializes frames MSB-first and hands completed words out through a valid/ready buffer.
- Flags framing errors, timeouts and overflow.
- Used for on-board loopback of the DAC bus and as the checker in DAC-path benches.

Parameters:
- FRAME_BITS, 24, serial bits per frame (2..32).
- TIMEOUT_CYCLES, 4096, clk cycles without a serial-clock falling edge while sync is low before the frame is aborted.
- SYNC_STAGES, 2, synchronizer flops per serial input (>=2).

Ports:
- clk  input  1  fabric clock (clk_160 domain).
- reset  input  1  asynchronous, active-high reset.
- ser_clk  input  1  serial clock, asynchronous to clk.
- ser_nsync  input  1  active-low frame sync, asynchronous to clk.
- ser_din  input  1  serial data, asynchronous to clk.
- frame_data  output  FRAME_BITS  last completed frame, MSB = first bit received.
- frame_valid  output  1  frame_data holds an unconsumed frame.
- frame_ready  input  1  consumer accepts frame_data when frame_valid && frame_ready.
- err_short  output  1  sticky: sync rose with fewer than FRAME_BITS bits.
- err_long  output  1  sticky: more than FRAME_BITS falling edges in one frame.
- err_timeout  output  1  sticky: frame aborted by timeout.
- err_overflow  output  1  sticky: completed frame dropped because the buffer was full.
- clear_err  input  1  synchronous pulse; clears all sticky errors.
- busy  output  1  high while in SHIFT or ABORT.

Behaviour:
- Reset values:
  - frame_data=0, frame_valid=0, all err_*=0, busy=0.
  - Synchronizer flops reset to ser_clk=1, nsync=1, din=0.
  - FSM = IDLE; bit counter and timeout counter = 0.
- Inputs:
  - Each serial input passes through SYNC_STAGES flops.
  - One extra registered copy of the synchronized ser_clk and ser_nsync gives the edge detects.
  - Data is captured on the synchronized ser_clk falling edge, using the synchronized din value at that same cycle.
- FSM IDLE:
  - Synchronized nsync falling edge -> SHIFT.
  - On entry to SHIFT: shift register cleared, bit_cnt=0, timeout=0.
  - ser_clk edges are ignored in IDLE.
- FSM SHIFT:
  - On each ser_clk falling edge: shift_reg <= {shift_reg[FRAME_BITS-2:0], din}; bit_cnt increments, saturating at FRAME_BITS+1; timeout counter cleared.
  - Otherwise the timeout counter increments.
  - nsync rising edge:
    - bit_cnt==FRAME_BITS -> frame complete, go to IDLE.
    - bit_cnt<FRAME_BITS -> err_short=1, frame discarded, go to IDLE.
    - bit_cnt>FRAME_BITS -> err_long=1, frame discarded, go to IDLE.
  - A falling edge and a nsync rise in the same cycle: the bit is shifted first, then bit_cnt is evaluated including that bit.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with no edge -> err_timeout=1, go to ABORT.
- FSM ABORT: all edges ignored until the synchronized nsync is high -> IDLE. No frame is emitted.
- Output buffer (single entry):
  - A completed frame loads frame_data and sets frame_valid.
  - frame_valid && frame_ready: frame_valid clears next cycle, unless a new frame completes in the same cycle; then the new frame loads and frame_valid stays 1, with no overflow.
  - Frame completes while frame_valid && !frame_ready: the new frame is dropped, err_overflow=1, frame_data unchanged.
- Latency: nsync high first sampled by sync stage 1 at edge N -> frame_valid high after edge N+SYNC_STAGES+1 (N+3 at the default).
- Errors:
  - clear_err clears the sticky flags.
  - An error raised in the same cycle as clear_err remains set (set wins).
- busy = (state != IDLE).
- Reset mid-frame: everything returns to reset values immediately; the next frame is accepted only after a fresh nsync fall.

Optional Feature:
- DAC_SERIAL_RX_COUNTERS_EN.
- Defined:
  - Adds outputs frame_count[15:0] and error_count[15:0], both reset to 0.
  - frame_count increments on every frame loaded into the buffer.
  - error_count increments on every cycle that sets any err_* condition, including when the flag is already set.
  - Both counters wrap at 0xFFFF->0 and are cleared by clear_err.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Common setup: clk 160 MHz, ser_clk 5 MHz.
- Nominal frame: send 24 bits 0x3A5C01, then raise nsync, with frame_ready=1. Required: one-cycle frame_valid with frame_data=0x3A5C01; no errors set.
- Short frame: send 23 bits, then raise nsync. Required: err_short=1, frame_valid stays 0. A following good 0x000FFF frame is received correctly.
- Long frame: send 25 bits. Required: err_long=1, no frame emitted. clear_err then drops err_long to 0.
- Timeout: nsync low, 3 bits, then ser_clk held for 5000 clk cycles. Required: err_timeout=1 at cycle 4096 after the last edge; ser_clk edges are ignored until nsync goes high.
- Backpressure: frame_ready=0, send 0x111111 then 0x222222. Required: frame_data=0x111111, err_overflow=1. After frame_ready pulses, frame_valid=0.
- Reset mid-frame: assert reset after 12 bits, then send a full 0xABCDEF. Required: 0xABCDEF is received and errors stay 0. With DAC_SERIAL_RX_COUNTERS_EN, frame_count=1.

Source files
------------

// File: rtl/dac_serial_rx.sv
// Receiver for the 3-wire DAC programming bus: oversampled, MSB-first deserializer with a single-entry valid/ready buffer.
// Optional frame/error counters are enabled by defining DAC_SERIAL_RX_COUNTERS_EN.
module dac_serial_rx #(
  parameter int FRAME_BITS     = 24,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  ser_clk_i,
  input  logic                  ser_nsync_i,
  input  logic                  ser_din_i,
  output logic [FRAME_BITS-1:0] frame_data_o,
  output logic                  frame_valid_o,
  input  logic                  frame_ready_i,
  output logic                  err_short_o,
  output logic                  err_long_o,
  output logic                  err_timeout_o,
  output logic                  err_overflow_o,
  input  logic                  clear_err_i,
  output logic                  busy_o
`ifdef DAC_SERIAL_RX_COUNTERS_EN
  ,
  output logic [15:0]           frame_count_o,
  output logic [15:0]           error_count_o
`endif
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ABORT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] nsync_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   sclk_prev_q;
  logic                   nsync_prev_q;

  logic sclk_s;
  logic nsync_s;
  logic din_s;
  logic sclk_fall;
  logic nsync_fall;
  logic nsync_rise;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  done_q, done_d;

  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  load_frame;

  logic set_short;
  logic set_long;
  logic set_timeout;
  logic set_overflow;
  logic err_short_q;
  logic err_long_q;
  logic err_timeout_q;
  logic err_overflow_q;

  // Idle levels of the bus (clock high, sync high) so reset never fakes an edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sclk_sync_q  <= '1;
      nsync_sync_q <= '1;
      din_sync_q   <= '0;
      sclk_prev_q  <= 1'b1;
      nsync_prev_q <= 1'b1;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], ser_clk_i};
      nsync_sync_q <= {nsync_sync_q[SYNC_STAGES-2:0], ser_nsync_i};
      din_sync_q   <= {din_sync_q[SYNC_STAGES-2:0], ser_din_i};
      sclk_prev_q  <= sclk_sync_q[SYNC_STAGES-1];
      nsync_prev_q <= nsync_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign nsync_s    = nsync_sync_q[SYNC_STAGES-1];
  assign din_s      = din_sync_q[SYNC_STAGES-1];
  assign sclk_fall  = sclk_prev_q & ~sclk_s;
  assign nsync_fall = nsync_prev_q & ~nsync_s;
  assign nsync_rise = ~nsync_prev_q & nsync_s;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
    end
  end

  // A bit arriving with the sync rise is shifted first, so the length check uses cnt_d.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    done_d      = 1'b0;
    set_short   = 1'b0;
    set_long    = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (nsync_fall) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      SHIFT: begin
        if (sclk_fall) begin
          shift_d = {shift_q[FRAME_BITS-2:0], din_s};
          tmo_d   = '0;
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        if (nsync_rise) begin
          state_d = IDLE;
          if (cnt_d == CNT_FULL) begin
            done_d = 1'b1;
          end else if (cnt_d < CNT_FULL) begin
            set_short = 1'b1;
          end else begin
            set_long = 1'b1;
          end
        end else if (!sclk_fall && (tmo_q == TMO_LAST)) begin
          set_timeout = 1'b1;
          tmo_d       = '0;
          state_d     = ABORT;
        end
      end
      ABORT: begin
        if (nsync_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A consumer pop and a new frame in the same cycle reload the buffer without overflow.
  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    load_frame   = 1'b0;
    set_overflow = 1'b0;
    if (valid_q && frame_ready_i) begin
      valid_d = 1'b0;
    end
    if (done_q) begin
      if (!valid_q || frame_ready_i) begin
        load_frame = 1'b1;
        data_d     = shift_q;
        valid_d    = 1'b1;
      end else begin
        set_overflow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Sticky flags: a new error in the clearing cycle survives the clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_short_q    <= 1'b0;
      err_long_q     <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      err_short_q    <= (err_short_q & ~clear_err_i) | set_short;
      err_long_q     <= (err_long_q & ~clear_err_i) | set_long;
      err_timeout_q  <= (err_timeout_q & ~clear_err_i) | set_timeout;
      err_overflow_q <= (err_overflow_q & ~clear_err_i) | set_overflow;
    end
  end

`ifdef DAC_SERIAL_RX_COUNTERS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;
  logic        any_err_set;

  assign any_err_set = set_short | set_long | set_timeout | set_overflow;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= (clear_err_i ? 16'd0 : frame_cnt_q) + {15'd0, load_frame};
      err_cnt_q   <= (clear_err_i ? 16'd0 : err_cnt_q) + {15'd0, any_err_set};
    end
  end

  assign frame_count_o = frame_cnt_q;
  assign error_count_o = err_cnt_q;
`endif

  assign frame_data_o   = data_q;
  assign frame_valid_o  = valid_q;
  assign err_short_o    = err_short_q;
  assign err_long_o     = err_long_q;
  assign err_timeout_o  = err_timeout_q;
  assign err_overflow_o = err_overflow_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed bench for dac_serial_rx: 160 MHz fabric clock, 5 MHz serial clock, hand-computed expected values.
`timescale 1ns/1ps
module tb_dac_serial_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        ser_clk;
  logic        ser_nsync;
  logic        ser_din;
  logic        frame_ready;
  logic        clear_err;
  logic [23:0] frame_data;
  logic        frame_valid;
  logic        err_short;
  logic        err_long;
  logic        err_timeout;
  logic        err_overflow;
  logic        busy;
  logic [3:0]  errs;
`ifdef DAC_SERIAL_RX_COUNTERS_EN
  logic [15:0] frame_count;
  logic [15:0] error_count;
`endif

  int checks = 0;
  int errors = 0;

  always #3.125 clk = ~clk;

  assign errs = {err_overflow, err_timeout, err_long, err_short};

  dac_serial_rx #(
    .FRAME_BITS(24),
    .TIMEOUT_CYCLES(4096),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .ser_clk_i(ser_clk),
    .ser_nsync_i(ser_nsync),
    .ser_din_i(ser_din),
    .frame_data_o(frame_data),
    .frame_valid_o(frame_valid),
    .frame_ready_i(frame_ready),
    .err_short_o(err_short),
    .err_long_o(err_long),
    .err_timeout_o(err_timeout),
    .err_overflow_o(err_overflow),
    .clear_err_i(clear_err),
    .busy_o(busy)
`ifdef DAC_SERIAL_RX_COUNTERS_EN
    ,
    .frame_count_o(frame_count),
    .error_count_o(error_count)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBit(input logic b);
    ser_din = b;
    waitCycles(16);
    ser_clk = 1'b0;
    waitCycles(16);
    ser_clk = 1'b1;
  endtask

  // One framed transfer of nbits, MSB first; returns right after sync rises.
  task automatic applyStimulus(input logic [31:0] value, input int nbits);
    ser_nsync = 1'b0;
    waitCycles(16);
    for (int i = 0; i < nbits; i++) begin
      sendBit(value[nbits-1-i]);
    end
    waitCycles(16);
    ser_nsync = 1'b1;
  endtask

  task automatic watchFrame(output int firstIdx, output int width, output logic [23:0] data);
    firstIdx = 0;
    width    = 0;
    data     = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        if (firstIdx == 0) firstIdx = i;
        width++;
        data = frame_data;
      end
    end
  endtask

  task automatic pulseClear();
    clear_err = 1'b1;
    waitCycles(1);
    clear_err = 1'b0;
  endtask

  initial begin
    int          firstIdx;
    int          width;
    logic [23:0] data;

    reset       = 1'b1;
    ser_clk     = 1'b1;
    ser_nsync   = 1'b1;
    ser_din     = 1'b0;
    frame_ready = 1'b1;
    clear_err   = 1'b0;
    waitCycles(4);
    checkOutput("reset_data", 32'(frame_data), 32'h0);
    checkOutput("reset_valid", 32'(frame_valid), 32'h0);
    checkOutput("reset_errs", 32'(errs), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    waitCycles(4);

    $display("[TB] nominal frame");
    applyStimulus(32'h3A5C01, 24);
    watchFrame(firstIdx, width, data);
    checkOutput("nominal_latency", 32'(firstIdx), 32'd4);
    checkOutput("nominal_width", 32'(width), 32'd1);
    checkOutput("nominal_data", 32'(data), 32'h3A5C01);
    checkOutput("nominal_errs", 32'(errs), 32'h0);
    checkOutput("nominal_idle", 32'(busy), 32'h0);

    $display("[TB] short frame then good frame");
    applyStimulus(32'h1234, 23);
    watchFrame(firstIdx, width, data);
    checkOutput("short_errs", 32'(errs), 32'h1);
    checkOutput("short_no_frame", 32'(width), 32'd0);
    applyStimulus(32'h000FFF, 24);
    watchFrame(firstIdx, width, data);
    checkOutput("after_short_data", 32'(data), 32'h000FFF);
    checkOutput("after_short_width", 32'(width), 32'd1);
    checkOutput("after_short_sticky", 32'(errs), 32'h1);
    pulseClear();
    checkOutput("short_cleared", 32'(errs), 32'h0);

    $display("[TB] long frame");
    applyStimulus(32'h1ABCDEF, 25);
    watchFrame(firstIdx, width, data);
    checkOutput("long_errs", 32'(errs), 32'h2);
    checkOutput("long_no_frame", 32'(width), 32'd0);
    pulseClear();
    checkOutput("long_cleared", 32'(errs), 32'h0);

    $display("[TB] timeout");
    ser_nsync = 1'b0;
    waitCycles(16);
    sendBit(1'b1);
    sendBit(1'b0);
    ser_din = 1'b1;
    waitCycles(16);
    ser_clk = 1'b0;
    waitCycles(16);
    ser_clk = 1'b1;
    waitCycles(4082);
    checkOutput("timeout_before", 32'(err_timeout), 32'h0);
    checkOutput("timeout_busy_shift", 32'(busy), 32'h1);
    waitCycles(1);
    checkOutput("timeout_at_4096", 32'(err_timeout), 32'h1);
    waitCycles(900);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    checkOutput("abort_errs", 32'(errs), 32'h4);
    checkOutput("abort_busy", 32'(busy), 32'h1);
    checkOutput("abort_no_frame", 32'(frame_valid), 32'h0);
    ser_nsync = 1'b1;
    waitCycles(8);
    checkOutput("abort_exit_busy", 32'(busy), 32'h0);
    checkOutput("abort_exit_valid", 32'(frame_valid), 32'h0);
    pulseClear();
    checkOutput("timeout_cleared", 32'(errs), 32'h0);

    $display("[TB] backpressure");
    frame_ready = 1'b0;
    applyStimulus(32'h111111, 24);
    waitCycles(10);
    checkOutput("bp_first_valid", 32'(frame_valid), 32'h1);
    checkOutput("bp_first_data", 32'(frame_data), 32'h111111);
    checkOutput("bp_first_errs", 32'(errs), 32'h0);
    applyStimulus(32'h222222, 24);
    waitCycles(10);
    checkOutput("bp_kept_data", 32'(frame_data), 32'h111111);
    checkOutput("bp_overflow", 32'(errs), 32'h8);
    checkOutput("bp_still_valid", 32'(frame_valid), 32'h1);
    frame_ready = 1'b1;
    waitCycles(1);
    frame_ready = 1'b0;
    checkOutput("bp_popped", 32'(frame_valid), 32'h0);
    pulseClear();
    frame_ready = 1'b1;

    $display("[TB] reset mid-frame");
    ser_nsync = 1'b0;
    waitCycles(16);
    for (int i = 0; i < 12; i++) begin
      sendBit(i[0]);
    end
    checkOutput("mid_busy", 32'(busy), 32'h1);
    reset     = 1'b1;
    ser_nsync = 1'b1;
    ser_clk   = 1'b1;
    waitCycles(1);
    checkOutput("mid_reset_busy", 32'(busy), 32'h0);
    checkOutput("mid_reset_data", 32'(frame_data), 32'h0);
    checkOutput("mid_reset_valid", 32'(frame_valid), 32'h0);
    waitCycles(4);
    reset = 1'b0;
    waitCycles(8);
    applyStimulus(32'hABCDEF, 24);
    watchFrame(firstIdx, width, data);
    checkOutput("post_reset_data", 32'(data), 32'hABCDEF);
    checkOutput("post_reset_width", 32'(width), 32'd1);
    checkOutput("post_reset_errs", 32'(errs), 32'h0);
`ifdef DAC_SERIAL_RX_COUNTERS_EN
    checkOutput("post_reset_frame_count", 32'(frame_count), 32'd1);
    checkOutput("post_reset_error_count", 32'(error_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
